// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, schedule FSM states and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_e;

  function automatic logic [3:0] nk_of(key_len_e len);
    case (len)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e len);
    case (len)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as inverse (a^254, which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lanes over a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign dout[8*g +: 8] = sbox(din[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock through a
// single shared SubWord, with the full schedule kept in a random-access register file.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int NW     = 4 * (MAX_NK + 7)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_key_len,
  input  logic [32*MAX_NK-1:0]  i_cypher_key,
  input  logic [3:0]            i_rk_round,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_key_valid,
  output logic [3:0]            o_nr,
  output logic [127:0]          o_round_key
);

  localparam int IW = $clog2(NW);

  state_e               state;
  key_len_e             len_q;
  logic [32*MAX_NK-1:0] key_q;
  logic [31:0]          w_mem [NW];
  logic [IW-1:0]        idx;
  logic [2:0]           phase;
  logic [7:0]           rcon;

  logic [3:0]    nk;
  logic [IW-1:0] last_idx;
  key_len_e      start_len;
  logic          start_ok;

  // Nk/Nr derive from the latched code; the reset code KL_BAD yields 0 for both.
  assign nk        = nk_of(len_q);
  assign o_nr      = nr_of(len_q);
  assign last_idx  = IW'({o_nr, 2'b11});
  assign start_len = key_len_e'(i_key_len);
  assign start_ok  = (start_len != KL_BAD) && (int'(nk_of(start_len)) <= MAX_NK);

  logic [31:0] prev, back, sw_in, sw_out, temp, nxt_word;

  assign prev  = w_mem[idx - IW'(1)];
  assign back  = w_mem[idx - IW'(nk)];
  assign sw_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_comb begin
    temp = prev;
    if (phase == 3'd0)                   temp = sw_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && phase == 3'd4) temp = sw_out;
  end

  assign nxt_word = temp ^ back;

  // Storage carries no reset; reads are gated by o_key_valid.
  always_ff @(posedge i_clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < MAX_NK; j++)
        if (4'(j) < nk) w_mem[j] <= key_q[32*j +: 32];
    end else if (state == EXPAND) begin
      w_mem[idx] <= nxt_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      len_q       <= KL_BAD;
      key_q       <= '0;
      idx         <= IW'(4);
      phase       <= '0;
      rcon        <= 8'h01;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_key_valid <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (start_ok) begin
              len_q       <= start_len;
              key_q       <= i_cypher_key;
              o_key_valid <= 1'b0;
              o_busy      <= 1'b1;
              state       <= LOAD;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          idx   <= IW'(nk);
          phase <= '0;
          rcon  <= 8'h01;
          state <= EXPAND;
        end
        EXPAND: begin
          if (phase == 3'd0) rcon <= xtime(rcon);
          phase <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
          // idx stays on the last word so the read mux never leaves the array.
          if (idx == last_idx) begin
            o_done      <= 1'b1;
            o_key_valid <= 1'b1;
            o_busy      <= 1'b0;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_round_key = '0;
    if (o_key_valid && i_rk_round <= o_nr)
      for (int k = 0; k < 4; k++)
        o_round_key[32*k +: 32] = w_mem[IW'({i_rk_round, 2'(k)})];
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 expansion vectors.
module tb_aes_key_schedule_seq;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [1:0]   i_key_len = 2'b00;
  logic [255:0] i_cypher_key = '0;
  logic [3:0]   i_rk_round = 4'd0;
  logic         o_busy, o_done, o_err, o_key_valid;
  logic [3:0]   o_nr;
  logic [127:0] o_round_key;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  aes_key_schedule_seq dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_key_len    (i_key_len),
    .i_cypher_key (i_cypher_key),
    .i_rk_round   (i_rk_round),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_key_valid  (o_key_valid),
    .o_nr         (o_nr),
    .o_round_key  (o_round_key)
  );

  localparam logic [255:0] K128 = {128'hdeadbeef_cafef00d_12345678_9abcdef0,
    32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [255:0] K192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
    32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] K256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
    32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
  localparam logic [127:0] R10_128 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           lat;
    logic [3:0]   nr;
    logic [3:0]   rnd;
    logic [1:0]   wd;
    logic [31:0]  exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a run and return cycles from the accept edge to o_done; optionally
  // raise a second (must-be-ignored) AES-256 start after `inj` cycles.
  task automatic run(input logic [1:0] len, input logic [255:0] key, input int inj,
                     output int lat, output logic busy_load);
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b1; i_key_len = len; i_cypher_key = key;
    @(posedge i_clk);
    #1 busy_load = o_busy;
    @(negedge i_clk);
    i_start = 1'b0; i_key_len = 2'b11; i_cypher_key = {8{$urandom()}};
    lat = 0;
    while (lat < 200) begin
      @(posedge i_clk);
      lat++;
      #1;
      if (o_done) break;
      if (lat == inj) begin
        i_start = 1'b1; i_key_len = 2'b10;
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    i_rk_round = 4'd0;
    #1;
    check({tag, " busy"},  {127'd0, o_busy}, 128'd0);
    check({tag, " done"},  {127'd0, o_done}, 128'd0);
    check({tag, " err"},   {127'd0, o_err}, 128'd0);
    check({tag, " valid"}, {127'd0, o_key_valid}, 128'd0);
    check({tag, " nr"},    {124'd0, o_nr}, 128'd0);
    check({tag, " rk"},    o_round_key, 128'd0);
  endtask

  initial begin
    int   lat;
    logic bl;
    int   dseen;

    vecs[0] = '{2'b00, K128, 41, 4'd10, 4'd1,  2'd0, 32'ha0fafe17};
    vecs[1] = '{2'b00, K128, 41, 4'd10, 4'd10, 2'd3, 32'hb6630ca6};
    vecs[2] = '{2'b00, K128, 41, 4'd10, 4'd0,  2'd0, 32'h2b7e1516};
    vecs[3] = '{2'b01, K192, 47, 4'd12, 4'd1,  2'd2, 32'hfe0c91f7};
    vecs[4] = '{2'b01, K192, 47, 4'd12, 4'd12, 2'd3, 32'h01002202};
    vecs[5] = '{2'b10, K256, 53, 4'd14, 4'd2,  2'd0, 32'h9ba35411};
    vecs[6] = '{2'b10, K256, 53, 4'd14, 4'd14, 2'd3, 32'h706c631e};

    repeat (2) @(posedge i_clk);
    check_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run(vecs[v].len, vecs[v].key, 0, lat, bl);
      check($sformatf("v%0d latency", v), 128'(lat), 128'(vecs[v].lat));
      check($sformatf("v%0d busy_load", v), {127'd0, bl}, 128'd1);
      check($sformatf("v%0d busy_done", v), {127'd0, o_busy}, 128'd0);
      check($sformatf("v%0d nr", v), {124'd0, o_nr}, {124'd0, vecs[v].nr});
      i_rk_round = vecs[v].rnd;
      #1 check($sformatf("v%0d word", v), {96'd0, o_round_key[32*vecs[v].wd +: 32]},
               {96'd0, vecs[v].exp});
    end

    // Second start mid-EXPAND must not disturb the AES-128 run.
    run(2'b00, K128, 10, lat, bl);
    check("ign latency", 128'(lat), 128'd41);
    check("ign nr", {124'd0, o_nr}, 128'd10);
    i_rk_round = 4'd10;
    #1 check("ign r10", o_round_key, R10_128);
    i_rk_round = 4'd11;
    #1 check("r11 gated", o_round_key, 128'd0);

    // Illegal code: error pulse, no busy, previous schedule still readable.
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b1; i_key_len = 2'b11;
    @(posedge i_clk);
    #1;
    check("bad err", {127'd0, o_err}, 128'd1);
    check("bad busy", {127'd0, o_busy}, 128'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    check("bad err off", {127'd0, o_err}, 128'd0);
    check("bad busy2", {127'd0, o_busy}, 128'd0);
    check("bad valid", {127'd0, o_key_valid}, 128'd1);
    i_rk_round = 4'd10;
    #1 check("bad keep r10", o_round_key, R10_128);

    // Reset in the middle of an AES-256 expansion.
    @(negedge i_clk);
    i_start = 1'b1; i_key_len = 2'b10; i_cypher_key = K256;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (19) @(posedge i_clk);
    #1 check("mid busy", {127'd0, o_busy}, 128'd1);
    i_rst_n = 1'b0;
    check_zero("midrst");
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    dseen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge i_clk);
      #1 if (o_done || o_busy) dseen++;
    end
    check("post rst idle", 128'(dseen), 128'd0);
    run(2'b00, K128, 0, lat, bl);
    check("rerun latency", 128'(lat), 128'd41);
    i_rk_round = 4'd10;
    #1 check("rerun r10", o_round_key, R10_128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
